// File: rtl/hello_pkg.sv
// Shared definitions for the hello_world UART reporter: FSM encoding,
// message length and default clocking.
package hello_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int MSG_LEN = 14;
    localparam logic [3:0] LAST_BYTE = 4'(MSG_LEN - 1);

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

endpackage

// File: rtl/hello_msg_rom.sv
// Combinational lookup of the "Hello world!\r\n" message; unused slots read as zero.
module hello_msg_rom (
    input  logic [3:0] i_idx,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            4'd0:    o_byte = 8'h48;
            4'd1:    o_byte = 8'h65;
            4'd2:    o_byte = 8'h6C;
            4'd3:    o_byte = 8'h6C;
            4'd4:    o_byte = 8'h6F;
            4'd5:    o_byte = 8'h20;
            4'd6:    o_byte = 8'h77;
            4'd7:    o_byte = 8'h6F;
            4'd8:    o_byte = 8'h72;
            4'd9:    o_byte = 8'h6C;
            4'd10:   o_byte = 8'h64;
            4'd11:   o_byte = 8'h21;
            4'd12:   o_byte = 8'h0D;
            4'd13:   o_byte = 8'h0A;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/hello_uart_tx.sv
// 8N1 transmitter that sends the fixed greeting once per rising edge of start.
// All outputs are flops, so tx is glitch-free.
module hello_uart_tx
    import hello_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD         = DEF_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic tx,
    output logic busy,
    output logic done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_idx;
    logic             r_start_q;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_trigger;
    logic             w_bit_end;
    logic [2:0]       w_next_bit;
    logic [7:0]       w_byte;

    hello_msg_rom u_rom (
        .i_idx  (r_byte_idx),
        .o_byte (w_byte)
    );

    assign w_trigger  = start & ~r_start_q;
    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_next_bit = r_bit_idx + 3'd1;

    // tx is loaded with the value of the next bit at each boundary, so it is
    // already correct on the first cycle of that bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_start_q  <= 1'b1;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start_q <= start;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (w_trigger) begin
                        r_state    <= ST_START;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= w_byte[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_byte[w_next_bit];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte_idx < LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_state    <= ST_START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_hello_uart_tx.sv
// Scoreboard bench for hello_uart_tx with a 4-clock bit period: a line decoder
// collects received bytes, each scenario pushes the bytes it expects.
module tb_hello_uart_tx;

    localparam int CPB = 4;
    localparam int MSG_CYC = 140 * CPB;

    logic clk;
    logic rst_n;
    logic start;
    logic tx;
    logic busy;
    logic done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    int exp_q[$];
    int rx_q[$];
    bit mon_clr = 1'b1;

    bit [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                           8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    hello_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Line decoder: samples mid-bit; a bad start or stop bit sets bit 8 of the pushed value.
    int       m_cyc = 0;
    bit       m_act = 1'b0;
    bit       m_ferr = 1'b0;
    logic [7:0] m_sh = 8'h00;
    always @(negedge clk) begin
        if (mon_clr) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act  <= 1'b1;
                m_cyc  <= 0;
                m_ferr <= 1'b0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % CPB == CPB / 2) begin
                if ((m_cyc + 1) / CPB == 0) begin
                    if (tx !== 1'b0) m_ferr <= 1'b1;
                end else if ((m_cyc + 1) / CPB <= 8) begin
                    m_sh <= {tx, m_sh[7:1]};
                end else begin
                    rx_q.push_back(((tx === 1'b1 && !m_ferr) ? 0 : 256) + int'(m_sh));
                    m_act <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg();
        for (int i = 0; i < 14; i++) exp_q.push_back(int'(msg[i]));
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mon_clr = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, expected 0", done); end
        rst_n = 1'b1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic test_full();
        int t_fall, t_done, bc0, dc0, e, r;
        logic [9:0] fr;
        logic got;
        bit ok;
        fr = {1'b1, 8'h48, 1'b0};
        push_msg();
        bc0 = busy_cnt;
        dc0 = done_cnt;
        start = 1'b1;
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL full_pre_tx: got %b, expected 1", tx); end
        tick();
        t_fall = cyc;
        n_cmp++;
        if (tx !== 1'b0) begin n_bad++; $display("FAIL full_latency_tx: got %b, expected 0", tx); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL full_latency_busy: got %b, expected 1", busy); end
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            got = fr[b];
            for (int c = 0; c < CPB; c++) begin
                if (tx !== fr[b]) begin ok = 1'b0; got = tx; end
                tick();
            end
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL frame_bit%0d: got %b, expected %b", b, got, fr[b]); end
        end
        start = 1'b0;
        wait_done(t_done);
        n_cmp++;
        if (t_done < 0 || t_done - t_fall != MSG_CYC) begin
            n_bad++; $display("FAIL full_done_time: got %0d, expected %0d", t_done < 0 ? -1 : t_done - t_fall, MSG_CYC);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_at_done: got %b, expected 0", busy); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL full_done_width: got %b, expected 0", done); end
        n_cmp++;
        if (done_cnt - dc0 != 1) begin n_bad++; $display("FAIL full_done_count: got %0d, expected 1", done_cnt - dc0); end
        n_cmp++;
        if (busy_cnt - bc0 != MSG_CYC) begin n_bad++; $display("FAIL full_busy_len: got %0d, expected %0d", busy_cnt - bc0, MSG_CYC); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL full_byte: got none, expected %02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r !== e) begin n_bad++; $display("FAIL full_byte: got %03h, expected %02h", r, e); end
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL full_extra: got %0d bytes, expected 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_ignore_extra();
        int t_done, dc0, e, r;
        int gaps[3] = '{47, 133, 201};
        push_msg();
        dc0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) begin
            repeat (gaps[p]) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        wait_done(t_done);
        n_cmp++;
        if (t_done < 0) begin n_bad++; $display("FAIL extra_done_seen: got timeout, expected done"); end
        repeat (60) tick();
        n_cmp++;
        if (done_cnt - dc0 != 1) begin n_bad++; $display("FAIL extra_done_count: got %0d, expected 1", done_cnt - dc0); end
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL extra_idle: got tx=%b busy=%b, expected tx=1 busy=0", tx, busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL extra_byte: got none, expected %02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r !== e) begin n_bad++; $display("FAIL extra_byte: got %03h, expected %02h", r, e); end
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL extra_extra: got %0d bytes, expected 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_done_trigger();
        int t_done, e, r;
        push_msg();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (MSG_CYC - 1) tick();
        start = 1'b1;
        tick();
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL dtrig_done: got %b, expected 1", done); end
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL dtrig_ignored: got tx=%b busy=%b, expected tx=1 busy=0", tx, busy); end
        start = 1'b0;
        tick();
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL dtrig_still_idle: got tx=%b busy=%b, expected tx=1 busy=0", tx, busy); end
        push_msg();
        start = 1'b1;
        tick();
        n_cmp++;
        if (tx !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL dtrig_restart: got tx=%b busy=%b, expected tx=0 busy=1", tx, busy); end
        start = 1'b0;
        tick();
        wait_done(t_done);
        n_cmp++;
        if (t_done < 0) begin n_bad++; $display("FAIL dtrig_done2: got timeout, expected done"); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL dtrig_byte: got none, expected %02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r !== e) begin n_bad++; $display("FAIL dtrig_byte: got %03h, expected %02h", r, e); end
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL dtrig_extra: got %0d bytes, expected 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int t_done, e, r;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5 * 10 * CPB + 3 * CPB) tick();
        rst_n = 1'b0;
        mon_clr = 1'b1;
        tick();
        n_cmp++;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b, expected 1", tx); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b, expected 0", done); end
        rst_n = 1'b1;
        tick();
        rx_q.delete();
        mon_clr = 1'b0;
        repeat (3) tick();
        push_msg();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(t_done);
        n_cmp++;
        if (t_done < 0) begin n_bad++; $display("FAIL rstmid_done2: got timeout, expected done"); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL rstmid_byte: got none, expected %02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r !== e) begin n_bad++; $display("FAIL rstmid_byte: got %03h, expected %02h", r, e); end
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL rstmid_extra: got %0d bytes, expected 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_start_held();
        int t_done, e, r;
        bit ok;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL held_no_tx: got activity, expected tx=1 busy=0"); end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL held_no_bytes: got %0d, expected 0", rx_q.size()); rx_q.delete(); end
        start = 1'b0;
        tick();
        push_msg();
        start = 1'b1;
        tick();
        n_cmp++;
        if (tx !== 1'b0) begin n_bad++; $display("FAIL held_retrigger: got %b, expected 0", tx); end
        start = 1'b0;
        wait_done(t_done);
        n_cmp++;
        if (t_done < 0) begin n_bad++; $display("FAIL held_done: got timeout, expected done"); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin n_bad++; $display("FAIL held_byte: got none, expected %02h", e); end
            else begin
                r = rx_q.pop_front();
                if (r !== e) begin n_bad++; $display("FAIL held_byte: got %03h, expected %02h", r, e); end
            end
        end
        n_cmp++;
        if (rx_q.size() != 0) begin n_bad++; $display("FAIL held_extra: got %0d bytes, expected 0", rx_q.size()); rx_q.delete(); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_full();
        test_ignore_extra();
        test_done_trigger();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hello_uart_tx.md
# hello_uart_tx

Serial transmitter that sends the fixed string "Hello world!" followed by CR LF (14 bytes) over an 8N1 UART line to the Nexys3 USB-UART bridge. Each rising edge of `start` triggers one transmission. `start` is normally driven by the Button input. This block is the board-to-host direction of the hello_world design: the existing top reads the user inputs, and this block reports back to the host PC.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (10416): clock cycles per UART bit. This is an overridable localparam-style parameter; the bench sets it to 4.

Ports:
- `clk`, input, 1: system clock. Every flop is clocked on its rising edge.
- `rst_n`, input, 1: reset. Synchronous and active-low; it is sampled only on the `clk` rising edge.
- `start`, input, 1: transmit request. The block acts on its rising edge. The input is synchronised and debounced upstream.
- `tx`, output, 1: UART serial line. It idles high.
- `busy`, output, 1: high from the first start bit until the final stop bit completes.
- `done`, output, 1: one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, byte index=0, bit index=0, baud counter=0, `start_q`=1.
- Resetting `start_q` to 1 means a `start` that is already high when reset releases does not trigger a transmission.
- Edge detection: `start_q` registers `start` every cycle. A trigger is the condition `start & ~start_q` while the state is IDLE.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: `tx`=1. On a trigger, go to START, load byte index 0, set `busy`=1.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=byte[bit index], sent LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if byte index < 13, increment the index and go to START with no idle gap. Otherwise go to IDLE, clear `busy`, and pulse `done`.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Its width is $clog2(CLKS_PER_BIT).
- Message bytes, in order: 48 65 6C 6C 6F 20 77 6F 72 6C 64 21 0D 0A (hex).
- Rising edges on `start` while `busy`=1 are ignored and are not queued.
- `start` held high after completion does not retrigger; a new 0→1 transition is required.
- A trigger on the same cycle as `done` is ignored, because the state is not IDLE on that cycle.
- Reset mid-frame: on the next clock edge, `tx` returns to 1 and `busy`=0. No partial byte is resumed after reset.

## Timing
- Trigger at clock edge N means `start`=1 and `start_q`=0 are sampled at edge N. `tx` falls to 0 and `busy` rises to 1 from edge N+1. Latency is one cycle.
- Frame length is 10×CLKS_PER_BIT cycles. The full message is 140×CLKS_PER_BIT cycles.
- `done` is high for exactly one cycle: the first cycle after the final stop bit. `busy` is 0 on that same cycle.
- `tx` is registered and glitch-free. All outputs come directly from flops.

## Structure
- Shared package `hello_pkg` holds:
  - the state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - `MSG_LEN`=14;
  - the default `CLK_FREQ` and `BAUD`.
- Sub-module `hello_msg_rom` is a combinational 4-bit index to 8-bit byte lookup of the message. Indices 14–15 return 8'h00.
- The top level `hello_uart_tx` contains the edge detector, the baud counter, the bit and byte indices, and the state machine.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset release with `start`=0, then one rising edge of `start` → `tx` falls one cycle later. The first frame reads start bit 0, data 0,0,0,1,0,0,1,0 ('H'=0x48, LSB first), then stop bit 1, each bit held 4 cycles.
- Full transmission decoded by the bench UART model → exactly the 14 bytes 48 65 6C 6C 6F 20 77 6F 72 6C 64 21 0D 0A. `done` pulses once, exactly 560 cycles after `tx` first falls. `busy` is high for exactly 560 cycles.
- Three extra `start` pulses issued during the transmission → still exactly 14 bytes and one `done`. The line idles high afterwards.
- `start` held high through reset release → no transmission, and `tx` stays 1. Dropping `start` and raising it again → a normal transmission.
- `rst_n` asserted low during the DATA state of byte 5 → `tx`=1, `busy`=0, `done`=0 on the next edge. A following trigger sends the message from 'H' again.
- Trigger on the cycle `done` is high → ignored. A trigger one cycle later → a new transmission starts, with `tx` falling one cycle after it.
